// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: valid/ready pipeline stage register with optional 2-entry skid, flush, bubble insertion and debug counters
module pipe_stage_skid_reg #(
    parameter int CTRL_W  = 8,
    parameter int DATA_W  = 64,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic              r_main_v;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [1:0]        r_occ;
    logic [CNT_W-1:0]  r_bub;
    logic              w_skid_v;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_main_v_n;
    logic [CTRL_W-1:0] w_main_ctrl_n;
    logic [DATA_W-1:0] w_main_data_n;
    logic              w_skid_v_n;
    logic [CTRL_W-1:0] w_skid_ctrl_n;
    logic [DATA_W-1:0] w_skid_data_n;
    logic              w_accept;
    logic              w_load;
    assign w_accept = in_valid & in_ready;
    assign w_load   = !r_main_v | out_ready;
    always_comb begin
        w_main_v_n    = r_main_v;
        w_main_ctrl_n = r_main_ctrl;
        w_main_data_n = r_main_data;
        w_skid_v_n    = w_skid_v;
        w_skid_ctrl_n = w_skid_ctrl;
        w_skid_data_n = w_skid_data;
        if (flush) begin
            w_main_v_n    = 1'b0;
            w_main_ctrl_n = '0;
            w_skid_v_n    = 1'b0;
            w_skid_ctrl_n = '0;
        end else if (w_load) begin
            // skid is always older than the input, so it wins the main slot
            if (w_skid_v) begin
                w_main_v_n    = 1'b1;
                w_main_ctrl_n = w_skid_ctrl;
                w_main_data_n = w_skid_data;
                w_skid_v_n    = 1'b0;
                w_skid_ctrl_n = '0;
            end else if (w_accept) begin
                w_main_v_n    = 1'b1;
                w_main_ctrl_n = in_ctrl;
                w_main_data_n = in_data;
            end else begin
                w_main_v_n    = 1'b0;
                w_main_ctrl_n = '0;
            end
        end else if (w_accept) begin
            w_skid_v_n    = 1'b1;
            w_skid_ctrl_n = in_ctrl;
            w_skid_data_n = in_data;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_v    <= 1'b0;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_occ       <= 2'd0;
            r_bub       <= '0;
        end else begin
            r_main_v    <= w_main_v_n;
            r_main_ctrl <= w_main_ctrl_n;
            r_main_data <= w_main_data_n;
            r_occ       <= {1'b0, w_main_v_n} + {1'b0, w_skid_v_n};
            if (out_ready && !r_main_v && r_bub != {CNT_W{1'b1}})
                r_bub <= r_bub + CNT_W'(1);
        end
    end
    generate
        if (SKID_EN != 0) begin : g_skid
            logic              r_skid_v;
            logic              r_in_ready;
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_skid_v    <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                end else begin
                    r_skid_v    <= w_skid_v_n;
                    r_in_ready  <= !w_skid_v_n;
                    r_skid_ctrl <= w_skid_ctrl_n;
                    r_skid_data <= w_skid_data_n;
                end
            end
            assign w_skid_v    = r_skid_v;
            assign w_skid_ctrl = r_skid_ctrl;
            assign w_skid_data = r_skid_data;
            assign in_ready    = r_in_ready;
        end else begin : g_noskid
            assign w_skid_v    = 1'b0;
            assign w_skid_ctrl = '0;
            assign w_skid_data = '0;
            assign in_ready    = !r_main_v | out_ready;
        end
    endgenerate
    assign out_valid  = r_main_v;
    assign out_ctrl   = r_main_ctrl;
    assign out_data   = r_main_data;
    assign occupancy  = r_occ;
    assign bubble_cnt = r_bub;
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: directed vector bench for skid (CNT_W=2) and no-skid stage variants
module tb_pipe_stage_skid_reg;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_flush = 1'b0, a_iv = 1'b0, a_ordy = 1'b0;
    logic [7:0]  a_ic = '0;
    logic [63:0] a_id = '0;
    logic        a_ir, a_ov;
    logic [7:0]  a_oc;
    logic [63:0] a_od;
    logic [1:0]  a_occ;
    logic [1:0]  a_bub;
    logic        b_iv = 1'b0, b_ordy = 1'b0;
    logic [7:0]  b_ic = '0;
    logic [63:0] b_id = '0;
    logic        b_ir, b_ov;
    logic [7:0]  b_oc;
    logic [63:0] b_od;
    logic [1:0]  b_occ;
    logic [15:0] b_bub;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.CTRL_W(8), .DATA_W(64), .SKID_EN(1), .CNT_W(2)) u_a (
        .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
        .in_ctrl(a_ic), .in_data(a_id), .out_valid(a_ov), .out_ready(a_ordy),
        .out_ctrl(a_oc), .out_data(a_od), .occupancy(a_occ), .bubble_cnt(a_bub));

    pipe_stage_skid_reg #(.CTRL_W(8), .DATA_W(64), .SKID_EN(0), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(b_iv), .in_ready(b_ir),
        .in_ctrl(b_ic), .in_data(b_id), .out_valid(b_ov), .out_ready(b_ordy),
        .out_ctrl(b_oc), .out_data(b_od), .occupancy(b_occ), .bubble_cnt(b_bub));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        fl;
        logic        iv;
        logic [7:0]  ic;
        logic [63:0] id;
        logic        ordy;
        logic        rdy;
        logic        ov;
        logic [7:0]  oc;
        logic [63:0] od;
        logic [1:0]  occ;
    } vec_t;

    vec_t vt[18];

    initial begin
        vt[0]  = '{0, 1, 8'h0F, 64'hA5, 1, 1, 1, 8'h0F, 64'hA5, 1};
        vt[1]  = '{0, 1, 8'h3C, 64'h5A, 1, 1, 1, 8'h3C, 64'h5A, 1};
        vt[2]  = '{0, 0, 8'h00, 64'h00, 0, 1, 1, 8'h3C, 64'h5A, 1};
        vt[3]  = '{0, 0, 8'h00, 64'h00, 1, 1, 0, 8'h00, 64'h5A, 0};
        vt[4]  = '{0, 0, 8'h00, 64'h00, 0, 1, 0, 8'h00, 64'h5A, 0};
        vt[5]  = '{0, 1, 8'h01, 64'h11, 0, 1, 1, 8'h01, 64'h11, 1};
        vt[6]  = '{0, 1, 8'h02, 64'h22, 0, 1, 1, 8'h01, 64'h11, 2};
        vt[7]  = '{0, 1, 8'h03, 64'h33, 0, 0, 1, 8'h01, 64'h11, 2};
        vt[8]  = '{0, 1, 8'h03, 64'h33, 1, 0, 1, 8'h02, 64'h22, 1};
        vt[9]  = '{0, 1, 8'h03, 64'h33, 1, 1, 1, 8'h03, 64'h33, 1};
        vt[10] = '{0, 0, 8'h00, 64'h00, 1, 1, 0, 8'h00, 64'h33, 0};
        vt[11] = '{0, 1, 8'h0A, 64'hAA, 0, 1, 1, 8'h0A, 64'hAA, 1};
        vt[12] = '{0, 1, 8'h0B, 64'hBB, 0, 1, 1, 8'h0A, 64'hAA, 2};
        vt[13] = '{1, 1, 8'h77, 64'h77, 0, 0, 0, 8'h00, 64'hAA, 0};
        vt[14] = '{0, 0, 8'h00, 64'h00, 0, 1, 0, 8'h00, 64'hAA, 0};
        vt[15] = '{0, 1, 8'h0C, 64'hCC, 0, 1, 1, 8'h0C, 64'hCC, 1};
        vt[16] = '{1, 1, 8'h77, 64'h77, 0, 1, 0, 8'h00, 64'hCC, 0};
        vt[17] = '{0, 0, 8'h00, 64'h00, 0, 1, 0, 8'h00, 64'hCC, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_ov", a_ov, 0);
        chk("rst_a_oc", a_oc, 0);
        chk("rst_a_od", a_od, 0);
        chk("rst_a_occ", a_occ, 0);
        chk("rst_a_bub", a_bub, 0);
        chk("rst_a_ir", a_ir, 0);
        chk("rst_b_ir", b_ir, 1);
        reset = 1'b0;
        #1 chk("rel_a_ir_pre", a_ir, 0);
        @(posedge clk);
        #1 chk("rel_a_ir_post", a_ir, 1);

        for (int i = 0; i < 18; i++) begin
            a_flush = vt[i].fl;
            a_iv    = vt[i].iv;
            a_ic    = vt[i].ic;
            a_id    = vt[i].id;
            a_ordy  = vt[i].ordy;
            #1 chk($sformatf("v%0d_ir", i), a_ir, vt[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ov", i), a_ov, vt[i].ov);
            chk($sformatf("v%0d_oc", i), a_oc, vt[i].oc);
            chk($sformatf("v%0d_od", i), a_od, vt[i].od);
            chk($sformatf("v%0d_occ", i), a_occ, vt[i].occ);
        end
        a_flush = 1'b0;
        chk("bub_after_table", a_bub, 1);

        a_iv = 1'b0;
        a_ordy = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bub%0d_cnt", k), a_bub, (k + 1 > 3) ? 3 : k + 1);
            chk($sformatf("bub%0d_oc", k), a_oc, 0);
        end

        b_iv = 1'b1; b_ic = 8'h21; b_id = 64'h2121; b_ordy = 1'b0;
        @(posedge clk);
        #1;
        chk("b_load_ov", b_ov, 1);
        chk("b_load_oc", b_oc, 8'h21);
        chk("b_load_occ", b_occ, 1);
        chk("b_stall_ir", b_ir, 0);
        b_ic = 8'h22; b_id = 64'h2222; b_ordy = 1'b1;
        #1 chk("b_comb_ir", b_ir, 1);
        @(posedge clk);
        #1;
        chk("b_swap_ov", b_ov, 1);
        chk("b_swap_oc", b_oc, 8'h22);
        chk("b_swap_od", b_od, 64'h2222);
        chk("b_swap_occ", b_occ, 1);
        b_iv = 1'b0;

        a_ordy = 1'b0; a_iv = 1'b1; a_ic = 8'h0D; a_id = 64'hDD;
        @(posedge clk);
        #1 a_ic = 8'h0E; a_id = 64'hEE;
        @(posedge clk);
        #1;
        a_iv = 1'b0;
        chk("ar_pre_occ", a_occ, 2);
        chk("ar_pre_oc", a_oc, 8'h0D);
        #2 reset = 1'b1;
        #1;
        chk("ar_ov", a_ov, 0);
        chk("ar_oc", a_oc, 0);
        chk("ar_od", a_od, 0);
        chk("ar_occ", a_occ, 0);
        chk("ar_bub", a_bub, 0);
        chk("ar_b_ov", b_ov, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
